// File: rtl/pt5_stream_unpacker.sv
// PT-5 stream unpacker: each lane byte (five base-3 digits) is expanded into five
// 2-bit trits, through a two-stage valid/ready pipeline that counts illegal bytes.
module pt5_stream_unpacker #(
    parameter int LANES     = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [8*LANES-1:0]     s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [10*LANES-1:0]    m_trits,
    output logic                   m_last,
    output logic [LANES-1:0]       m_err,
    output logic [ERR_CNT_W-1:0]   err_count,
    input  logic                   err_clr
);
    localparam int PCW  = $clog2(LANES + 1);
    localparam int SUMW = ERR_CNT_W + PCW;

    // Digit of weight w in r, given that r < 3*w.
    function automatic logic [1:0] trit_at(input logic [7:0] r, input logic [7:0] w);
        if ({1'b0, r} >= {w, 1'b0}) return 2'd2;
        else if (r >= w)            return 2'd1;
        else                        return 2'd0;
    endfunction

    function automatic logic [7:0] strip(input logic [7:0] r, input logic [1:0] t, input logic [7:0] w);
        return r - ((t == 2'd2) ? {w[6:0], 1'b0} : ((t == 2'd1) ? w : 8'd0));
    endfunction

    function automatic logic [9:0] pt5_decode(input logic [7:0] b);
        logic [7:0] r;
        logic [1:0] t4, t3, t2, t1, t0;
        r  = b;
        t4 = trit_at(r, 8'd81); r = strip(r, t4, 8'd81);
        t3 = trit_at(r, 8'd27); r = strip(r, t3, 8'd27);
        t2 = trit_at(r, 8'd9);  r = strip(r, t2, 8'd9);
        t1 = trit_at(r, 8'd3);  r = strip(r, t1, 8'd3);
        t0 = trit_at(r, 8'd1);
        return (b > 8'd242) ? 10'd0 : {t4, t3, t2, t1, t0};
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + PCW'(v[i]);
        return c;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a, input logic [PCW-1:0] b);
        logic [SUMW-1:0] s;
        s = SUMW'(a) + SUMW'(b);
        if (|s[SUMW-1:ERR_CNT_W]) return '1;
        else                      return s[ERR_CNT_W-1:0];
    endfunction

    logic                  adv1, adv2;
    logic                  vld_p1_q, vld_p2_q;
    logic                  last_p1_q, last_p2_q;
    logic [8*LANES-1:0]    data_p1_q;
    logic [10*LANES-1:0]   trits_p2_q, trits_p2_d;
    logic [LANES-1:0]      err_p2_q, err_p2_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    assign adv2    = ~vld_p2_q | m_ready;
    assign adv1    = ~vld_p1_q | adv2;
    assign s_ready = rst_n & adv1;

    always_comb begin
        trits_p2_d = '0;
        err_p2_d   = '0;
        for (int i = 0; i < LANES; i++) begin
            trits_p2_d[10*i +: 10] = pt5_decode(data_p1_q[8*i +: 8]);
            err_p2_d[i]            = data_p1_q[8*i +: 8] > 8'd242;
        end
    end

    // A clear wins over a same-cycle handshake, dropping that beat's errors.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)                    err_cnt_d = '0;
        else if (vld_p2_q && m_ready)   err_cnt_d = sat_add(err_cnt_q, popcount(err_p2_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            last_p1_q  <= 1'b0;
            data_p1_q  <= '0;
            vld_p2_q   <= 1'b0;
            last_p2_q  <= 1'b0;
            trits_p2_q <= '0;
            err_p2_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            // stage 1: capture raw packed beat
            if (adv1) vld_p1_q <= s_valid;
            if (s_valid && adv1) begin
                data_p1_q <= s_data;
                last_p1_q <= s_last;
            end
            // stage 2: decoded trits and error flags
            if (adv2) vld_p2_q <= vld_p1_q;
            if (vld_p1_q && adv2) begin
                trits_p2_q <= trits_p2_d;
                err_p2_q   <= err_p2_d;
                last_p2_q  <= last_p1_q;
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_valid   = vld_p2_q;
    assign m_trits   = trits_p2_q;
    assign m_last    = last_p2_q;
    assign m_err     = err_p2_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_pt5_stream_unpacker.sv
// Bench for pt5_stream_unpacker: fixed vectors, hand-built corner sequences and a
// randomized stream compared against a queue-based reference model.
module tb_pt5_stream_unpacker;
    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [39:0] m_trits;
    logic        m_last;
    logic [3:0]  m_err;
    logic [15:0] err_count;
    logic        err_clr;

    pt5_stream_unpacker #(.LANES(4), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_trits(m_trits), .m_last(m_last),
        .m_err(m_err), .err_count(err_count), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [39:0] trits;
        logic [3:0]  err;
    } vec_t;

    typedef struct {
        logic [39:0] trits;
        logic [3:0]  err;
        logic        last;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_in  = 0;
    int   n_out = 0;
    int   n_11  = 0;
    int   model_cnt = 0;
    bit   in_hs, out_hs;
    logic seen_s_ready;
    exp_t q[$];
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Reference decode straight from the base-3 definition.
    function automatic exp_t ref_beat(input logic [31:0] d, input logic l);
        exp_t e;
        int   v;
        e.trits = '0;
        e.err   = '0;
        e.last  = l;
        for (int i = 0; i < 4; i++) begin
            v = int'(d[8*i +: 8]);
            if (v > 242) e.err[i] = 1'b1;
            else for (int k = 0; k < 5; k++) begin
                e.trits[10*i + 2*k +: 2] = 2'(v % 3);
                v = v / 3;
            end
        end
        return e;
    endfunction

    // Inputs are already set; observe this cycle's handshakes, then advance one clock.
    task automatic cycle();
        exp_t e;
        #1;
        seen_s_ready = s_ready;
        in_hs  = s_valid && s_ready;
        out_hs = m_valid && m_ready;
        if (in_hs) begin
            q.push_back(ref_beat(s_data, s_last));
            n_in++;
        end
        if (out_hs) begin
            n_out++;
            for (int k = 0; k < 20; k++) if (m_trits[2*k +: 2] == 2'b11) n_11++;
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL extra_beat: got trits 0x%0h, required no output", m_trits);
            end else begin
                e = q.pop_front();
                chk("beat", {19'd0, m_trits, m_err, m_last}, {19'd0, e.trits, e.err, e.last});
                model_cnt = model_cnt + $countones(e.err);
                if (model_cnt > 65535) model_cnt = 65535;
            end
        end
        if (err_clr) model_cnt = 0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen(input int mode, input int idx, input logic [31:0] fixed);
        logic [31:0] d;
        d = fixed;
        if (mode == 0) d = $urandom;
        if (mode == 2) for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(idx + 37 * i);
        return d;
    endfunction

    task automatic stream(input int mode, input int nbeats, input logic [31:0] fixed,
                          input int vld_pct, input int rdy_pct);
        int idx = 0;
        int budget = 0;
        while ((idx < nbeats || q.size() > 0) && budget < nbeats * 20 + 100) begin
            s_valid = (idx < nbeats) && ($urandom_range(99) < vld_pct);
            s_data  = gen(mode, idx, fixed);
            s_last  = 1'($urandom_range(1));
            m_ready = $urandom_range(99) < rdy_pct;
            cycle();
            if (in_hs) idx++;
            budget++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("stream_done", {32'(idx), 32'(q.size())}, {32'(nbeats), 32'd0});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tbl_cnt, o0, i0, low, mv;
        logic [39:0] held;

        vecs[0] = '{32'h05F27900, 1'b0, {10'h006, 10'h2AA, 10'h155, 10'h000}, 4'b0000};
        vecs[1] = '{32'hFF79F379, 1'b1, {10'h000, 10'h155, 10'h000, 10'h155}, 4'b1010};
        vecs[2] = '{32'hFFFFFFFF, 1'b0, 40'd0,                                  4'b1111};
        vecs[3] = '{32'h04030201, 1'b1, {10'h005, 10'h004, 10'h002, 10'h001}, 4'b0000};
        vecs[4] = '{32'h5100F3F2, 1'b0, {10'h100, 10'h000, 10'h000, 10'h2AA}, 4'b0010};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_trits", m_trits, 0);
        chk("rst_m_last_err", {m_last, m_err}, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        cycle();
        chk("s_ready_after_rst", s_ready, 1);

        // Table of single beats, latency two cycles.
        tbl_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = vecs[i].data; s_last = vecs[i].last; m_ready = 1'b1;
            cycle();
            s_valid = 1'b0;
            cycle();
            chk($sformatf("tbl%0d_valid", i), m_valid, 1);
            chk($sformatf("tbl%0d_trits", i), m_trits, vecs[i].trits);
            chk($sformatf("tbl%0d_err_last", i), {m_err, m_last}, {vecs[i].err, vecs[i].last});
            cycle();
            tbl_cnt += $countones(vecs[i].err);
            chk($sformatf("tbl%0d_err_count", i), err_count, tbl_cnt);
            chk($sformatf("tbl%0d_idle", i), m_valid, 0);
        end

        // 100 back-to-back beats in 102 cycles.
        o0 = n_out; i0 = n_in; low = 0;
        for (int c = 0; c < 102; c++) begin
            s_valid = (n_in - i0) < 100;
            s_data  = $urandom;
            s_last  = 1'($urandom_range(1));
            m_ready = 1'b1;
            cycle();
            if (s_valid && !seen_s_ready) low++;
        end
        s_valid = 1'b0;
        chk("full_rate_outputs", n_out - o0, 100);
        chk("full_rate_ready_low", low, 0);

        // Full pipeline stalled for 5 cycles, then drained.
        i0 = n_in; o0 = n_out;
        m_ready = 1'b0; s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_data = $urandom; s_last = 1'($urandom_range(1));
            cycle();
        end
        chk("stall_accepted", n_in - i0, 2);
        held = m_trits;
        for (int c = 0; c < 5; c++) begin
            chk("stall_s_ready", s_ready, 0);
            chk("stall_trits_stable", m_trits, held);
            cycle();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("stall_drained", {32'(n_out - o0), 32'(q.size())}, {32'd2, 32'd0});

        // All 256 byte values in every lane under random backpressure.
        stream(2, 256, 32'd0, 80, 60);
        stream(0, 300, 32'd0, 70, 50);
        chk("err_count_model", err_count, model_cnt);

        // Saturation and clear.
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        chk("clr_idle", err_count, 0);
        stream(1, 16383, 32'hFFFFFFFF, 100, 100);
        stream(1, 1, 32'h0000F4F3, 100, 100);
        chk("err_count_fffe", err_count, 16'hFFFE);
        stream(1, 1, 32'h00FFFFFF, 100, 100);
        chk("err_count_sat", err_count, 16'hFFFF);
        stream(1, 1, 32'hFFFFFFFF, 100, 100);
        chk("err_count_hold", err_count, 16'hFFFF);
        s_valid = 1'b1; s_data = 32'hFFFFFFFF; m_ready = 1'b0;
        cycle();
        s_valid = 1'b0;
        cycle();
        chk("clr_hs_valid", m_valid, 1);
        m_ready = 1'b1; err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clr_on_handshake", err_count, 0);
        chk("clr_model", err_count, model_cnt);

        // Reset with two beats in flight.
        m_ready = 1'b0; s_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            s_data = $urandom; s_last = 1'b1;
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_trits", {m_trits, m_err, m_last}, 0);
        q.delete();
        model_cnt = 0;
        rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        cycle();
        chk("midrst_ready_back", s_ready, 1);
        mv = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (m_valid) mv++;
        end
        chk("midrst_no_output", mv, 0);
        chk("no_trit_11", n_11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pt5_stream_unpacker.md
# pt5_stream_unpacker

Streaming, parametrised PT-5 decoder for the ternary fabric. It accepts beats of LANES packed PT-5 bytes over a valid/ready handshake and emits LANES×5 two-bit trits per beat through a 2-stage elastic pipeline. It supports full-rate backpressure, frame marking, and flagging and counting of illegal bytes (>242). It sits between the packed-weight memory read port and the trit-lane compute array.

## Interface
- LANES, 4, packed bytes per input beat (1..16)
- ERR_CNT_W, 16, width of saturating illegal-byte counter

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous reset, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  8*LANES  lane i byte = s_data[8*i +: 8]
- s_last  in  1  final beat of frame, carried alongside data
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat consumed when m_valid & m_ready
- m_trits  out  10*LANES  lane i trit k = m_trits[10*i+2*k +: 2], k=0..4
- m_last  out  1  s_last of the corresponding input beat
- m_err  out  LANES  bit i set when lane i byte > 242
- err_count  out  ERR_CNT_W  saturating count of illegal lanes delivered
- err_clr  in  1  synchronous clear of err_count

## Operation
- Decode: byte = t0 + 3·t1 + 9·t2 + 27·t3 + 81·t4, each tk ∈ {0,1,2}. Trit encoding is 0→2'b00, 1→2'b01, 2→2'b10. 2'b11 is never produced.
- Illegal byte (243..255): all five trits of that lane are 2'b00 and the m_err bit is set. Other lanes decode normally.
- Decode is a per-lane constant mapping (ROM/LUT or mod-3 logic). No divide operators in synthesised logic.
- Pipeline: stage 1 registers s_data/s_last. Stage 2 registers decoded trits, m_err and m_last. Each stage has its own valid bit (v1, v2).
- Advance rules, with adv2 = ~v2 | m_ready and adv1 = ~v1 | adv2:
  - stage 2 loads when v1 & adv2
  - stage 1 loads when s_valid & adv1
- s_ready = adv1 (combinational from m_ready). This gives no bubbles under continuous m_ready.
- m_valid = v2. m_trits/m_last/m_err hold stable while m_valid & ~m_ready.
- err_count: on each output handshake, add popcount(m_err), saturating at 2^ERR_CNT_W−1.
  - err_clr has priority: a clear in the same cycle as a handshake leaves the counter at 0, and that beat's errors are dropped.
- Frame boundaries need no special handling. m_last simply follows its beat. Back-to-back frames are allowed.

## Timing
- Latency: a beat accepted at edge N appears on m_valid after edge N+2 (2 cycles) when unstalled.
- Throughput: 1 beat/cycle. Full pipeline stalls hold both stages. s_ready deasserts only when v1 & v2 & ~m_ready.
- Reset (rst_n low at an edge):
  - v1 = v2 = 0, so m_valid = 0
  - m_trits = 0, m_last = 0, m_err = 0, err_count = 0
  - s_ready is forced 0 while rst_n is low
- Reset mid-stream discards in-flight beats. No partial output follows reset. s_ready returns to 1 in the first cycle after rst_n rises.
- Simultaneous events:
  - With v2 & m_ready & v1 in one cycle, stage 2 reloads from stage 1 and stage 1 accepts a new s_data in the same cycle.
  - err_clr is honoured regardless of handshake state.

## Test plan
- Single beat, LANES=4, bytes {0x00,0x79,0xF2,0x05}, m_ready=1 → after 2 cycles, m_trits lanes = {10'h000, 10'h155, 10'h2AA, 10'h006}, m_err=0.
- Lane byte 0xF3 and 0xFF in lanes 1,3, others 0x79 → lanes 1,3 = 10'h000, m_err=4'b1010; after handshake, err_count=2.
- Exhaustive sweep of all 256 byte values per lane with random m_ready backpressure → trits match a reference decode, no 2'b11 ever appears, output order and count equal input, m_last is preserved.
- Continuous s_valid with m_ready=1 for 100 beats → 100 outputs in 102 cycles, s_ready constantly 1.
- m_ready held low for 5 cycles with a full pipeline → s_ready=0, m_trits stable. On release, beats drain in order with no loss or duplication.
- err_count at 0xFFFE plus a beat with 3 illegal lanes → 0xFFFF (saturated). err_clr on a handshake cycle → 0. rst_n pulsed mid-stream → m_valid=0 next cycle and in-flight beats are never emitted.
